// File: rtl/score_pkg.sv
// Shared constants, state encoding and points lookup for the score hit generator.
package score_pkg;

    // Combo bonus saturates here.
    localparam logic [1:0] COMBO_MAX = 2'd3;

    // Points per lines cleared, indexed by line count 0..4.
    localparam logic [4:0][3:0] PTS_LUT = {4'd8, 4'd5, 4'd3, 4'd1, 4'd0};

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        GAP,
        CLR
    } score_st_t;

    // Base points for a lock; anything above four lines scores as four.
    function automatic logic [3:0] pts_of(input logic [2:0] lines);
        logic [2:0] idx;
        idx = (lines > 3'd4) ? 3'd4 : lines;
        return PTS_LUT[idx];
    endfunction

endpackage

// File: rtl/score_hit_gen_if.sv
// Playfield-side event bus and counter-side pulse outputs of the score hit generator.
interface score_hit_gen_if;

    logic       clr_valid;
    logic [2:0] clr_lines;
    logic       game_over;
    logic       restart;
    logic       hit;
    logic       score_clr;
    logic       busy;

    modport master (
        output clr_valid, clr_lines, game_over, restart,
        input  hit, score_clr, busy
    );

    modport slave (
        input  clr_valid, clr_lines, game_over, restart,
        output hit, score_clr, busy
    );

endinterface

// File: rtl/score_hit_gen.sv
// Turns line-clear events into a paced train of one-cycle hit pulses, one per point,
// with a combo bonus, a saturating pending-points accumulator and a restart clear.
module score_hit_gen
    import score_pkg::*;
#(
    parameter int HIT_GAP = 2,
    parameter int PEND_W  = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    score_hit_gen_if.slave  bus
);

    localparam int                GW       = $clog2(HIT_GAP);
    localparam int                SW       = PEND_W + 4;
    localparam logic [GW-1:0]     GAP_LAST = GW'(HIT_GAP - 2);
    localparam logic [PEND_W-1:0] PEND_SAT = '1;

    score_st_t         r_state;
    logic [PEND_W-1:0] r_pend;
    logic [1:0]        r_combo;
    logic [GW-1:0]     r_gap_cnt;
    logic              r_hit;
    logic              r_clr;

    logic              w_accept;
    logic              w_pend_nz;
    logic              w_gap_done;
    logic              w_emit;
    logic [3:0]        w_add;
    logic [1:0]        w_combo_next;
    logic [SW-1:0]     w_sum;
    logic [PEND_W-1:0] w_pend_next;

    // Points added by this cycle's event, point consumed by this cycle's hit, and the
    // saturated accumulator value; both add and emit are honoured in the same cycle.
    always_comb begin
        w_accept     = bus.clr_valid && !bus.game_over && !bus.restart;
        w_pend_nz    = (r_pend != '0);
        w_gap_done   = (r_gap_cnt == GAP_LAST);
        w_emit       = w_pend_nz && ((r_state == IDLE) || ((r_state == GAP) && w_gap_done));
        w_add        = '0;
        w_combo_next = r_combo;
        if (w_accept) begin
            if (bus.clr_lines != '0) begin
                w_add        = pts_of(bus.clr_lines) + {2'b00, r_combo};
                w_combo_next = (r_combo == COMBO_MAX) ? COMBO_MAX : r_combo + 2'd1;
            end else begin
                w_combo_next = '0;
            end
        end
        w_sum       = SW'(r_pend) + SW'(w_add) - SW'(w_emit);
        w_pend_next = (w_sum > SW'(PEND_SAT)) ? PEND_SAT : w_sum[PEND_W-1:0];
    end

    // Pulse-train FSM with registered hit/score_clr; restart overrides every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pend    <= '0;
            r_combo   <= '0;
            r_gap_cnt <= '0;
            r_hit     <= 1'b0;
            r_clr     <= 1'b0;
        end else if (bus.restart) begin
            r_state   <= CLR;
            r_pend    <= '0;
            r_combo   <= '0;
            r_gap_cnt <= '0;
            r_hit     <= 1'b0;
            r_clr     <= 1'b1;
        end else begin
            r_pend  <= w_pend_next;
            r_combo <= w_combo_next;
            r_hit   <= 1'b0;
            r_clr   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_emit) begin
                        r_state <= EMIT;
                        r_hit   <= 1'b1;
                    end
                end
                EMIT: begin
                    r_state   <= GAP;
                    r_gap_cnt <= '0;
                end
                GAP: begin
                    if (w_gap_done) begin
                        if (w_emit) begin
                            r_state <= EMIT;
                            r_hit   <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                CLR: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.hit       = r_hit;
    assign bus.score_clr = r_clr;
    assign bus.busy      = w_pend_nz || r_hit;

endmodule
